// File: rtl/demux_8bus_1_4_stream.sv
// demux_8bus_1_4_stream: registered 1:4 demultiplexer for DATA_W-bit words.
// Latency: a word accepted at edge N is visible on its lane after edge N.
// Backpressure: o_ready = !full[i_sel]. Each lane stalls only on its own i_ready.
//
// Optional build macro: DEMUX_STATS_EN adds per-lane 8-bit delivered-word counters.
//
// Ports:
//   i_clk, i_rst          clock, asynchronous active-high reset
//   i_data, i_sel         input word and destination lane (qualified by i_valid)
//   i_valid / o_ready     input handshake; transfer when both are high
//   o_data[4*DATA_W]      lane k head word at [k*DATA_W +: DATA_W]
//   o_valid[4] / i_ready[4] per-lane output handshake
//   i_cnt_clr             synchronous clear of the lane counters (stats build)
//   o_xfer_cnt[32]        lane k delivered-word count at [k*8 +: 8]

// demux_8bus_1_4_stream_fifo: one lane FIFO with a registered head word.
// Latency: a push into an empty FIFO is visible after the same edge.
// Backpressure: o_full is registered occupancy only and does not look at i_ready.
module demux_8bus_1_4_stream_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_ready,
  output logic              o_full,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] OCC_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] OCC_ONE  = CW'(1);
  localparam logic [CW-1:0] OCC_ZERO = '0;
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr;
  logic [AW-1:0]     r_rd;
  logic [CW-1:0]     r_occ;
  logic [DATA_W-1:0] r_head;

  logic              w_push;
  logic              w_pop;
  logic [AW-1:0]     w_rd_nxt;
  logic [DATA_W-1:0] w_head_nxt;

  assign o_full   = (r_occ == OCC_FULL);
  assign o_valid  = (r_occ != OCC_ZERO);
  assign o_data   = r_head;

  assign w_push   = i_push && !o_full;
  assign w_pop    = o_valid && i_ready;
  // DEPTH is a power of two, so natural pointer overflow wraps modulo DEPTH.
  assign w_rd_nxt = r_rd + PTR_ONE;

  // The head is kept in its own register so o_data is a flop output and
  // holds its last value once the lane drains.
  always_comb begin
    w_head_nxt = r_head;
    if (w_pop) begin
      if (r_occ > OCC_ONE) begin
        // Next entry is already stored.
        w_head_nxt = r_mem[w_rd_nxt];
      end else if (w_push) begin
        // Last entry leaves while a new one arrives: the new word is the head.
        w_head_nxt = i_data;
      end
    end else if (!o_valid && w_push) begin
      w_head_nxt = i_data;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr   <= '0;
      r_rd   <= '0;
      r_occ  <= '0;
      r_head <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr] <= i_data;
        r_wr        <= r_wr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd <= w_rd_nxt;
      end
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + OCC_ONE;
        2'b01:   r_occ <= r_occ - OCC_ONE;
        default: r_occ <= r_occ;
      endcase
      r_head <= w_head_nxt;
    end
  end
endmodule

module demux_8bus_1_4_stream #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 2
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [DATA_W-1:0]   i_data,
  input  logic [1:0]          i_sel,
  input  logic                i_valid,
  output logic                o_ready,
  output logic [4*DATA_W-1:0] o_data,
  output logic [3:0]          o_valid,
  input  logic [3:0]          i_ready,
  input  logic                i_cnt_clr,
  output logic [31:0]         o_xfer_cnt
);
  logic [3:0] w_full;
  logic [3:0] w_push;

  // Ready depends only on the selected lane's registered occupancy, never on
  // i_ready, so a full lane cannot accept even if it is draining this cycle.
  assign o_ready = !w_full[i_sel];

  for (genvar gk = 0; gk < 4; gk++) begin : g_lane
    assign w_push[gk] = i_valid && o_ready && (i_sel == 2'(gk));

    demux_8bus_1_4_stream_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
    ) u_fifo (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_push  (w_push[gk]),
      .i_data  (i_data),
      .i_ready (i_ready[gk]),
      .o_full  (w_full[gk]),
      .o_valid (o_valid[gk]),
      .o_data  (o_data[gk*DATA_W +: DATA_W])
    );
  end

`ifdef DEMUX_STATS_EN
  logic [3:0] w_pop;
  logic [7:0] r_cnt [4];

  assign w_pop = o_valid & i_ready;

  // Clear wins over a same-cycle increment; counters wrap 255 -> 0.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int k = 0; k < 4; k++) begin
        r_cnt[k] <= '0;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (i_cnt_clr) begin
          r_cnt[k] <= '0;
        end else if (w_pop[k]) begin
          r_cnt[k] <= r_cnt[k] + 8'd1;
        end
      end
    end
  end

  assign o_xfer_cnt = {r_cnt[3], r_cnt[2], r_cnt[1], r_cnt[0]};
`else
  // Counters are absent; the clear input is accepted and ignored.
  logic w_unused_cnt_clr;
  assign w_unused_cnt_clr = i_cnt_clr;
  assign o_xfer_cnt       = '0;
`endif
endmodule
